// File: rtl/m216a_pe_checker.sv
// Golden-model result checker for the M216A PE: predicts D_Out per function/latency and scores it.
// Optional build macro M216A_CHK_STICKY_EN makes Mismatch_Out latch until reset.
module m216a_pe_checker #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              Clk_In,
   input  logic              Rst_In,
   input  logic [15:0]       Instruction_In,
   input  logic [DATA_W-1:0] D_In1,
   input  logic [DATA_W-1:0] D_In2,
   input  logic [DATA_W-1:0] D_In3,
   input  logic [DATA_W-1:0] Pe_Out_In,
   output logic [DATA_W-1:0] Exp_Out,
   output logic              Valid_Out,
   output logic              Mismatch_Out,
   output logic              Bad_Instr_Out,
   output logic [CNT_W-1:0]  Err_Count_Out,
   output logic [CNT_W-1:0]  Cmp_Count_Out
);

   localparam int HIST = 6;

   logic                        started;
   logic [15:0]                 prev_instr;
   logic [2:0]                  fill;
   logic [DATA_W-1:0]           x_h1, x_h2;
   logic [HIST-1:0][DATA_W-1:0] g_hist;   // g_hist[i] = G(n-1-i) seen at edge n

   logic                        new_stream, bad, valid_now, fail_now;
   logic [2:0]                  lat, fill_eff;
   logic [DATA_W-1:0]           x1, x2, g_now, e_now, b7, p_xa, p_ab, p_x21, p_x1x;
   logic [HIST-1:0][DATA_W-1:0] g_prev;

   always_comb begin
      new_stream = !started || (Instruction_In != prev_instr);
      bad        = (Instruction_In == 16'd0) || (Instruction_In > 16'd8);

      unique case (Instruction_In)
         16'd2, 16'd7: lat = 3'd4;
         16'd8:        lat = 3'd6;
         default:      lat = 3'd2;
      endcase

      // A new stream sees all history as zero, without waiting for a clear cycle
      x1       = new_stream ? '0 : x_h1;
      x2       = new_stream ? '0 : x_h2;
      g_prev   = new_stream ? '0 : g_hist;
      fill_eff = new_stream ? 3'd0 : fill;

      b7    = (D_In3 << 3) - D_In3;
      p_xa  = D_In1 * D_In2;
      p_ab  = D_In2 * D_In3;
      p_x21 = x2 * x1;
      p_x1x = x1 * D_In1;

      g_now = '0;
      unique case (Instruction_In)
         16'd1, 16'd2: g_now = D_In1;
         16'd3:        g_now = D_In2 + D_In3;
         16'd4:        g_now = p_xa;
         16'd5:        g_now = D_In1 + p_ab;
         16'd6:        g_now = g_prev[0] + b7;
         16'd7:        g_now = p_x21 + D_In1;
         16'd8:        g_now = g_prev[0] + p_x1x;
         default:      g_now = '0;
      endcase

      e_now = '0;
      unique case (lat)
         3'd2:    e_now = g_prev[1];
         3'd4:    e_now = g_prev[3];
         3'd6:    e_now = g_prev[5];
         default: e_now = '0;
      endcase

      valid_now = !bad && (fill_eff >= lat);
      fail_now  = valid_now && (Pe_Out_In != e_now);
   end

   always_ff @(posedge Clk_In or posedge Rst_In) begin
      if (Rst_In) begin
         started       <= 1'b0;
         prev_instr    <= '0;
         fill          <= '0;
         x_h1          <= '0;
         x_h2          <= '0;
         g_hist        <= '0;
         Exp_Out       <= '0;
         Valid_Out     <= 1'b0;
         Mismatch_Out  <= 1'b0;
         Bad_Instr_Out <= 1'b0;
         Err_Count_Out <= '0;
         Cmp_Count_Out <= '0;
      end else begin
         started       <= 1'b1;
         prev_instr    <= Instruction_In;
         Bad_Instr_Out <= bad;
         Valid_Out     <= valid_now;
         Exp_Out       <= valid_now ? e_now : '0;
`ifdef M216A_CHK_STICKY_EN
         Mismatch_Out  <= Mismatch_Out | fail_now;
`else
         Mismatch_Out  <= fail_now;
`endif
         if (valid_now && (Cmp_Count_Out != '1))
            Cmp_Count_Out <= Cmp_Count_Out + 1'b1;
         if (fail_now && (Err_Count_Out != '1))
            Err_Count_Out <= Err_Count_Out + 1'b1;
         // Bad codes freeze the model so the stream history is not polluted
         if (!bad) begin
            x_h1   <= D_In1;
            x_h2   <= x1;
            g_hist <= {g_prev[HIST-2:0], g_now};
            fill   <= (fill_eff < lat) ? fill_eff + 3'd1 : lat;
         end
      end
   end

endmodule

// File: tb/tb_m216a_pe_checker.sv
// Directed table-driven bench for m216a_pe_checker; expectations hand-derived from the golden definitions.
module tb_m216a_pe_checker;

   logic        Clk_In = 1'b0;
   logic        Rst_In;
   logic [15:0] Instruction_In, D_In1, D_In2, D_In3, Pe_Out_In;
   logic [15:0] Exp_Out, Err_Count_Out, Cmp_Count_Out;
   logic        Valid_Out, Mismatch_Out, Bad_Instr_Out;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] instr, x, a, b, pe;
      logic        ev;
      logic [15:0] eo;
      logic        em, eb;
   } vec_t;

   vec_t tbl[$];

   m216a_pe_checker #(.DATA_W(16), .CNT_W(16)) dut (
      .Clk_In(Clk_In), .Rst_In(Rst_In), .Instruction_In(Instruction_In),
      .D_In1(D_In1), .D_In2(D_In2), .D_In3(D_In3), .Pe_Out_In(Pe_Out_In),
      .Exp_Out(Exp_Out), .Valid_Out(Valid_Out), .Mismatch_Out(Mismatch_Out),
      .Bad_Instr_Out(Bad_Instr_Out), .Err_Count_Out(Err_Count_Out),
      .Cmp_Count_Out(Cmp_Count_Out)
   );

   always #5 Clk_In = ~Clk_In;

`ifdef M216A_CHK_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   function automatic void add(input logic [15:0] i, x, a, b, pe,
                               input logic ev, input logic [15:0] eo,
                               input logic em, eb);
      vec_t v;
      v.instr = i; v.x = x; v.a = a; v.b = b; v.pe = pe;
      v.ev = ev; v.eo = eo; v.em = em; v.eb = eb;
      tbl.push_back(v);
   endfunction

   task automatic step(input vec_t v, input string nm, input int idx);
      Instruction_In = v.instr; D_In1 = v.x; D_In2 = v.a; D_In3 = v.b; Pe_Out_In = v.pe;
      @(posedge Clk_In); #1;
      tests++;
      if (Valid_Out !== v.ev || Exp_Out !== v.eo || Mismatch_Out !== v.em || Bad_Instr_Out !== v.eb) begin
         fails++;
         $display("FAIL %s[%0d]: got valid=%0b exp=%0d mis=%0b bad=%0b, want valid=%0b exp=%0d mis=%0b bad=%0b",
                  nm, idx, Valid_Out, Exp_Out, Mismatch_Out, Bad_Instr_Out, v.ev, v.eo, v.em, v.eb);
      end
   endtask

   task automatic run_tbl(input string nm);
      foreach (tbl[i]) step(tbl[i], nm, i);
      tbl.delete();
   endtask

   task automatic check_cnt(input string nm, input logic [15:0] cmp, err);
      tests++;
      if (Cmp_Count_Out !== cmp || Err_Count_Out !== err) begin
         fails++;
         $display("FAIL %s: got cmp=%0d err=%0d, want cmp=%0d err=%0d",
                  nm, Cmp_Count_Out, Err_Count_Out, cmp, err);
      end
   endtask

   task automatic check_zero(input string nm);
      tests++;
      if (Exp_Out !== 16'd0 || Valid_Out !== 1'b0 || Mismatch_Out !== 1'b0 || Bad_Instr_Out !== 1'b0 ||
          Err_Count_Out !== 16'd0 || Cmp_Count_Out !== 16'd0) begin
         fails++;
         $display("FAIL %s: got exp=%0d valid=%0b mis=%0b bad=%0b err=%0d cmp=%0d, want all 0",
                  nm, Exp_Out, Valid_Out, Mismatch_Out, Bad_Instr_Out, Err_Count_Out, Cmp_Count_Out);
      end
   endtask

   task automatic pulse_reset();
      Rst_In = 1'b1;
      #2;
      check_zero("reset");
      @(negedge Clk_In);
      Rst_In = 1'b0;
   endtask

   initial begin
      Rst_In = 1'b1;
      Instruction_In = 0; D_In1 = 0; D_In2 = 0; D_In3 = 0; Pe_Out_In = 0;
      #12;
      check_zero("reset_state");
      Rst_In = 1'b0;

      // F4: x=i, a=i+3, G(n)=(n+1)(n+4), E(n)=(n-1)(n+2)
      for (int n = 0; n <= 10; n++)
         add(16'd4, 16'(n + 1), 16'(n + 4), 16'd0,
             (n >= 2) ? 16'((n - 1) * (n + 2)) : 16'd0,
             n >= 2, (n >= 2) ? 16'((n - 1) * (n + 2)) : 16'd0, 1'b0, 1'b0);
      run_tbl("f4_seq");
      check_cnt("f4_counts", 16'd9, 16'd0);

      // F6: G = 56, 119, ...
      add(6, 0, 0, 8,  0,   0, 0,   0, 0);
      add(6, 0, 0, 9,  0,   0, 0,   0, 0);
      add(6, 0, 0, 10, 56,  1, 56,  0, 0);
      add(6, 0, 0, 11, 119, 1, 119, 0, 0);
      run_tbl("f6_seq");

      // F8 x=1..9: G = 0,2,8,...  (x(-1) reads as 0, so G(0)=0)
      for (int n = 0; n <= 5; n++) add(8, 16'(n + 1), 0, 0, 0, 0, 0, 0, 0);
      add(8, 7, 0, 0, 0, 1, 0, 0, 0);
      add(8, 8, 0, 0, 2, 1, 2, 0, 0);
      add(8, 9, 0, 0, 8, 1, 8, 0, 0);
      run_tbl("f8_seq");
      check_cnt("f6_f8_counts", 16'd14, 16'd0);

      // F1 with a single corrupted PE output at n=5
      for (int n = 0; n <= 7; n++)
         add(16'd1, 16'(3 + 5 * n), 16'd0, 16'd0,
             (n >= 2) ? 16'(3 + 5 * (n - 2) + ((n == 5) ? 1 : 0)) : 16'd0,
             n >= 2, (n >= 2) ? 16'(3 + 5 * (n - 2)) : 16'd0,
             STICKY ? (n >= 5) : (n == 5), 1'b0);
      run_tbl("f1_corrupt");
      check_cnt("f1_corrupt_counts", 16'd20, 16'd1);

      pulse_reset();

      // Overflow boundaries: 300*300 mod 2^16, FFFF+2
      add(4, 300, 300, 0, 0,     0, 0,     0, 0);
      add(4, 300, 300, 0, 0,     0, 0,     0, 0);
      add(4, 300, 300, 0, 24464, 1, 24464, 0, 0);
      add(3, 0, 16'hFFFF, 2, 0, 0, 0, 0, 0);
      add(3, 0, 16'hFFFF, 2, 0, 0, 0, 0, 0);
      add(3, 0, 16'hFFFF, 2, 1, 1, 1, 0, 0);
      run_tbl("overflow");

      // F1 -> F2 switch: four dead samples, then E = first F2 operand
      for (int n = 0; n <= 3; n++)
         add(1, 16'(10 + n), 0, 0, (n >= 2) ? 16'(8 + n) : 16'd0,
             n >= 2, (n >= 2) ? 16'(8 + n) : 16'd0, 0, 0);
      for (int m = 0; m <= 5; m++)
         add(2, 16'(100 + m), 0, 0, (m >= 4) ? 16'(96 + m) : 16'd0,
             m >= 4, (m >= 4) ? 16'(96 + m) : 16'd0, 0, 0);
      run_tbl("switch_f1_f2");
      check_cnt("switch_counts", 16'd6, 16'd0);

      // Bad instruction: no compare, counters frozen even with a wrong PE value
      add(9, 5, 5, 5, 16'hDEAD, 0, 0, 0, 1);
      add(9, 6, 6, 6, 16'hBEEF, 0, 0, 0, 1);
      add(0, 6, 6, 6, 16'hBEEF, 0, 0, 0, 1);
      run_tbl("bad_instr");
      check_cnt("bad_counts", 16'd6, 16'd0);

      // F7 stream interrupted by an asynchronous reset between edges
      add(7, 2, 0, 0, 0, 0, 0, 0, 0);
      add(7, 3, 0, 0, 0, 0, 0, 0, 0);
      add(7, 4, 0, 0, 0, 0, 0, 0, 0);
      run_tbl("f7_pre");
      Rst_In = 1'b1;
      #1;
      check_zero("async_reset");
      #2;
      Rst_In = 1'b0;
      // x=7..12: G(0)=0*0+7, G(1)=0*7+8
      add(7, 7,  0, 0, 0, 0, 0, 0, 0);
      add(7, 8,  0, 0, 0, 0, 0, 0, 0);
      add(7, 9,  0, 0, 0, 0, 0, 0, 0);
      add(7, 10, 0, 0, 0, 0, 0, 0, 0);
      add(7, 11, 0, 0, 7, 1, 7, 0, 0);
      add(7, 12, 0, 0, 8, 1, 8, 0, 0);
      run_tbl("f7_post");
      check_cnt("f7_counts", 16'd2, 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
